// File: rtl/dmem_master_if.sv
// Pipeline-side request/response and data-memory signals of the dmem stall-protocol initiator.
// The master modport is the initiator's view; slave is the pipeline + memory side.
interface dmem_master_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [2:0]  req_sign_mask_i;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_w_data_o;
  logic        mem_w_ena_o;
  logic        mem_r_ena_o;
  logic [2:0]  mem_sign_mask_o;
  logic [31:0] mem_r_data_i;
  logic        mem_stall_i;

  modport master (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_sign_mask_i,
           mem_r_data_i, mem_stall_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
           mem_addr_o, mem_w_data_o, mem_w_ena_o, mem_r_ena_o, mem_sign_mask_o
  );

  modport slave (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_sign_mask_i,
           mem_r_data_i, mem_stall_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
           mem_addr_o, mem_w_data_o, mem_w_ena_o, mem_r_ena_o, mem_sign_mask_o
  );
endinterface

// File: rtl/dmem_master.sv
// CPU-side initiator for the data-memory stall protocol: one load/store at a time,
// single-cycle enable pulse, then follows the memory's registered stall through rise and fall.
module dmem_master #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CHECK_ALIGN    = 1
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  dmem_master_if.master bus
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_HI, S_WAIT_LO, S_RESP, S_RESP_ERR
  } state_t;

  state_t      r_state, w_nxt;
  logic [CW-1:0] r_cnt;
  logic        r_we;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [2:0]  r_sm;

  logic w_accept, w_bad, w_cap, w_clr_rdata;

  assign w_accept = bus.req_valid_i && (r_state == S_IDLE);

  always_comb begin
    w_bad = (bus.req_sign_mask_i[1:0] == 2'b11);
    if (CHECK_ALIGN != 0) begin
      if (bus.req_sign_mask_i[1:0] == 2'b01 && bus.req_addr_i[0])
        w_bad = 1'b1;
      if (bus.req_sign_mask_i[1:0] == 2'b10 && bus.req_addr_i[1:0] != 2'b00)
        w_bad = 1'b1;
    end
  end

  always_comb begin
    w_nxt       = r_state;
    w_cap       = 1'b0;
    w_clr_rdata = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept) begin
        w_nxt       = w_bad ? S_RESP_ERR : S_ISSUE;
        w_clr_rdata = w_bad;
      end
      S_ISSUE: w_nxt = S_WAIT_HI;
      // Stall has priority over the timeout, so a stall seen in the last allowed cycle still wins.
      S_WAIT_HI: if (bus.mem_stall_i) w_nxt = S_WAIT_LO;
                 else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                   w_nxt       = S_RESP_ERR;
                   w_clr_rdata = 1'b1;
                 end
      S_WAIT_LO: if (!bus.mem_stall_i) begin
        w_nxt = S_RESP;
        w_cap = 1'b1;
      end
      S_RESP:     w_nxt = S_IDLE;
      S_RESP_ERR: w_nxt = S_IDLE;
      default:    w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_sm    <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_accept) begin
        r_we    <= bus.req_we_i;
        r_addr  <= bus.req_addr_i;
        r_wdata <= bus.req_wdata_i;
        r_sm    <= bus.req_sign_mask_i;
      end
      if (r_state == S_ISSUE)
        r_cnt <= '0;
      else if (r_state == S_WAIT_HI && !bus.mem_stall_i)
        r_cnt <= r_cnt + CW'(1);
      if (w_cap)
        r_rdata <= r_we ? 32'h0 : bus.mem_r_data_i;
      else if (w_clr_rdata)
        r_rdata <= 32'h0;
    end
  end

  // Enables decode from ISSUE only, so the memory never sees a stale enable.
  assign bus.req_ready_o     = (r_state == S_IDLE);
  assign bus.resp_valid_o    = (r_state == S_RESP) || (r_state == S_RESP_ERR);
  assign bus.resp_err_o      = (r_state == S_RESP_ERR);
  assign bus.resp_rdata_o    = r_rdata;
  assign bus.mem_w_ena_o     = (r_state == S_ISSUE) && r_we;
  assign bus.mem_r_ena_o     = (r_state == S_ISSUE) && !r_we;
  assign bus.mem_addr_o      = r_addr;
  assign bus.mem_w_data_o    = r_wdata;
  assign bus.mem_sign_mask_o = r_sm;
endmodule
